// File: rtl/alu_arbiter_pkg.sv
// Shared constants for the ALU arbiter: FSM encodings, flag-vector layout and
// the ALU opcode set that requesters place on op_i.
package alu_arbiter_pkg;

    localparam logic [1:0] ARB_IDLE = 2'd0;
    localparam logic [1:0] ARB_EXEC = 2'd1;
    localparam logic [1:0] ARB_FLAG = 2'd2;
    localparam logic [1:0] ARB_RESP = 2'd3;

    localparam int FLG_ZF = 3;
    localparam int FLG_SF = 2;
    localparam int FLG_CF = 1;
    localparam int FLG_OF = 0;

    localparam logic [3:0] OP_ADD   = 4'h0;
    localparam logic [3:0] OP_SUB   = 4'h1;
    localparam logic [3:0] OP_AND   = 4'h2;
    localparam logic [3:0] OP_OR    = 4'h3;
    localparam logic [3:0] OP_XOR   = 4'h4;
    localparam logic [3:0] OP_NOT   = 4'h5;
    localparam logic [3:0] OP_NEG   = 4'h6;
    localparam logic [3:0] OP_CMP   = 4'h7;
    localparam logic [3:0] OP_MOV   = 4'h8;
    localparam logic [3:0] OP_MOVHI = 4'h9;
    localparam logic [3:0] OP_MOVLO = 4'hA;

    function automatic logic [3:0] pack_flags(input logic zf, input logic sf,
                                              input logic cf, input logic of);
        logic [3:0] f;
        f         = '0;
        f[FLG_ZF] = zf;
        f[FLG_SF] = sf;
        f[FLG_CF] = cf;
        f[FLG_OF] = of;
        return f;
    endfunction

endpackage

// File: rtl/alu_arbiter_rr_pick.sv
// Combinational round-robin selector: first asserted request at or above ptr_i,
// wrapping modulo NREQ.
module rr_pick #(
    parameter int NREQ = 2,
    parameter int IDXW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDXW-1:0] ptr_i,
    output logic            valid_o,
    output logic [IDXW-1:0] winner_o
);

    int idx;

    // NOTE: every output gets a default before the loop so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        valid_o  = 1'b0;
        winner_o = '0;
        idx      = 0;
        // Walk from farthest to nearest so the nearest hit is the last write.
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = int'(ptr_i) + i;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (req_i[IDXW'(idx)]) begin
                valid_o  = 1'b1;
                winner_o = IDXW'(idx);
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between NREQ requesters: round-robin grant, one enabled ALU
// cycle, flag capture, then a one-cycle one-hot ack with result and flags.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDXW = $clog2(NREQ)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NREQ-1:0]    req_i,
    input  logic [4*NREQ-1:0]  op_i,
    input  logic [16*NREQ-1:0] data1_i,
    input  logic [16*NREQ-1:0] data2_i,
    output logic [NREQ-1:0]    ack_o,
    output logic [15:0]        rsp_data_o,
    output logic [3:0]         rsp_flags_o,
    output logic               busy_o,
    output logic [3:0]         alu_op_o,
    output logic [15:0]        alu_data1_o,
    output logic [15:0]        alu_data2_o,
    output logic               alu_en_o,
    input  logic [15:0]        alu_data_i,
    input  logic               alu_zf_i,
    input  logic               alu_sf_i,
    input  logic               alu_cf_i,
    input  logic               alu_of_i
);

    logic [1:0]      state_q, state_d;
    logic [IDXW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDXW-1:0] winner_q, winner_d;
    logic [3:0]      op_q, op_d;
    logic [15:0]     data1_q, data1_d;
    logic [15:0]     data2_q, data2_d;
    logic [15:0]     rsp_data_q, rsp_data_d;
    logic [3:0]      rsp_flags_q, rsp_flags_d;
    logic [NREQ-1:0] ack_q, ack_d;

    logic            pick_valid;
    logic [IDXW-1:0] pick_idx;
    logic [3:0]      op_sel;
    logic [15:0]     data1_sel, data2_sel;

    rr_pick #(.NREQ(NREQ), .IDXW(IDXW)) u_rr_pick (
        .req_i    (req_i),
        .ptr_i    (rr_ptr_q),
        .valid_o  (pick_valid),
        .winner_o (pick_idx)
    );

    always_comb begin
        op_sel    = '0;
        data1_sel = '0;
        data2_sel = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (pick_idx == IDXW'(k)) begin
                op_sel    = op_i[k*4 +: 4];
                data1_sel = data1_i[k*16 +: 16];
                data2_sel = data2_i[k*16 +: 16];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        winner_d    = winner_q;
        op_d        = op_q;
        data1_d     = data1_q;
        data2_d     = data2_q;
        rsp_data_d  = rsp_data_q;
        rsp_flags_d = rsp_flags_q;
        ack_d       = '0;
        case (state_q)
            ARB_IDLE: begin
                if (pick_valid) begin
                    winner_d = pick_idx;
                    op_d     = op_sel;
                    data1_d  = data1_sel;
                    data2_d  = data2_sel;
                    rr_ptr_d = (pick_idx == IDXW'(NREQ - 1)) ? '0 : pick_idx + IDXW'(1);
                    state_d  = ARB_EXEC;
                end
            end
            ARB_EXEC: begin
                rsp_data_d = alu_data_i;
                state_d    = ARB_FLAG;
            end
            ARB_FLAG: begin
                // ALU flags are registered, so they are only valid one cycle after EXEC.
                rsp_flags_d     = pack_flags(alu_zf_i, alu_sf_i, alu_cf_i, alu_of_i);
                ack_d[winner_q] = 1'b1;
                state_d         = ARB_RESP;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q     <= ARB_IDLE;
            rr_ptr_q    <= '0;
            winner_q    <= '0;
            op_q        <= '0;
            data1_q     <= '0;
            data2_q     <= '0;
            rsp_data_q  <= '0;
            rsp_flags_q <= '0;
            ack_q       <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            winner_q    <= winner_d;
            op_q        <= op_d;
            data1_q     <= data1_d;
            data2_q     <= data2_d;
            rsp_data_q  <= rsp_data_d;
            rsp_flags_q <= rsp_flags_d;
            ack_q       <= ack_d;
        end
    end

    assign ack_o       = ack_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_flags_o = rsp_flags_q;
    assign busy_o      = (state_q != ARB_IDLE);
    assign alu_en_o    = (state_q == ARB_EXEC);
    assign alu_op_o    = op_q;
    assign alu_data1_o = data1_q;
    assign alu_data2_o = data2_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural ALU, table of single-requester ops and
// hand-written sequences for contention, latency, reset abort and operand hold.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    localparam int NREQ = 2;

    logic              clk = 1'b0;
    logic              rst_i;
    logic [NREQ-1:0]   req_i;
    logic [4*NREQ-1:0] op_i;
    logic [16*NREQ-1:0] data1_i, data2_i;
    logic [NREQ-1:0]   ack_o;
    logic [15:0]       rsp_data_o;
    logic [3:0]        rsp_flags_o;
    logic              busy_o, alu_en_o;
    logic [3:0]        alu_op;
    logic [15:0]       alu_d1, alu_d2, alu_res;
    logic              alu_zf, alu_sf, alu_cf, alu_of;

    alu_arbiter #(.NREQ(NREQ)) dut (
        .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .op_i(op_i),
        .data1_i(data1_i), .data2_i(data2_i), .ack_o(ack_o),
        .rsp_data_o(rsp_data_o), .rsp_flags_o(rsp_flags_o), .busy_o(busy_o),
        .alu_op_o(alu_op), .alu_data1_o(alu_d1), .alu_data2_o(alu_d2),
        .alu_en_o(alu_en_o), .alu_data_i(alu_res),
        .alu_zf_i(alu_zf), .alu_sf_i(alu_sf), .alu_cf_i(alu_cf), .alu_of_i(alu_of)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: combinational result, flags registered on enabled cycles.
    logic [16:0] wide;
    logic        nx_cf, nx_of, upd;
    always_comb begin
        wide = '0; alu_res = '0; nx_cf = 1'b0; nx_of = 1'b0; upd = 1'b0;
        case (alu_op)
            OP_ADD: begin
                wide = {1'b0, alu_d1} + {1'b0, alu_d2}; alu_res = wide[15:0]; upd = 1'b1;
                nx_cf = wide[16];
                nx_of = (alu_d1[15] == alu_d2[15]) && (alu_res[15] != alu_d1[15]);
            end
            OP_SUB, OP_CMP: begin
                wide = {1'b0, alu_d1} - {1'b0, alu_d2}; alu_res = wide[15:0]; upd = 1'b1;
                nx_cf = wide[16];
                nx_of = (alu_d1[15] != alu_d2[15]) && (alu_res[15] != alu_d1[15]);
            end
            OP_AND:   begin alu_res = alu_d1 & alu_d2; upd = 1'b1; end
            OP_OR:    begin alu_res = alu_d1 | alu_d2; upd = 1'b1; end
            OP_XOR:   begin alu_res = alu_d1 ^ alu_d2; upd = 1'b1; end
            OP_NOT:   alu_res = ~alu_d1;
            OP_NEG:   alu_res = 16'h0000 - alu_d1;
            OP_MOV:   alu_res = alu_d1;
            OP_MOVHI: alu_res = {alu_d2[7:0], alu_d1[7:0]};
            OP_MOVLO: alu_res = {alu_d1[15:8], alu_d2[7:0]};
            default:  alu_res = '0;
        endcase
    end

    always @(posedge clk) begin
        if (!rst_i) {alu_zf, alu_sf, alu_cf, alu_of} <= 4'b0000;
        else if (alu_en_o && upd)
            {alu_zf, alu_sf, alu_cf, alu_of} <= {alu_res == 16'h0, alu_res[15], nx_cf, nx_of};
    end

    typedef struct {
        logic [NREQ-1:0] ack;
        logic [15:0]     data;
        logic [3:0]      flags;
    } exp_t;

    typedef struct {
        logic [3:0]  op;
        logic [15:0] a, b;
        logic [15:0] exp_data;
        logic [3:0]  exp_flags;
    } vec_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0h, want %0h", name, act, exp);
        else n_pass++;
    endtask

    // Scoreboard monitor: every ack cycle must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (ack_o !== '0) begin
            if (sb.size() == 0) begin
                check("ack_unexpected", 32'(ack_o), 32'h0);
            end else begin
                e = sb.pop_front();
                check("ack_vec", 32'(ack_o), 32'(e.ack));
                check("rsp_data", 32'(rsp_data_o), 32'(e.data));
                check("rsp_flags", 32'(rsp_flags_o), 32'(e.flags));
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic drive(input int k, input logic [3:0] op, input logic [15:0] a,
                         input logic [15:0] b);
        op_i[k*4 +: 4]     = op;
        data1_i[k*16 +: 16] = a;
        data2_i[k*16 +: 16] = b;
        req_i[k]            = 1'b1;
    endtask

    task automatic push(input int k, input logic [15:0] d, input logic [3:0] f);
        exp_t e;
        e.ack = '0; e.ack[k] = 1'b1; e.data = d; e.flags = f;
        sb.push_back(e);
    endtask

    task automatic wait_ack(input int k, output int cycles);
        bit ok = 1'b0;
        cycles = 0;
        for (int c = 0; c < 20 && !ok; c++) begin
            tick();
            cycles++;
            if (ack_o[k]) ok = 1'b1;
        end
        if (!ok) check("ack_timeout", 32'(k), 32'hFFFF);
    endtask

    task automatic do_txn(input int k, input logic [3:0] op, input logic [15:0] a,
                          input logic [15:0] b, input logic [15:0] d, input logic [3:0] f);
        int c;
        drive(k, op, a, b);
        push(k, d, f);
        wait_ack(k, c);
        req_i[k] = 1'b0;
    endtask

    vec_t vecs[11];
    int   c0, c1, c2;

    initial begin
        vecs[0]  = '{OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 4'b1010};
        vecs[1]  = '{OP_SUB, 16'h8000, 16'h0001, 16'h7FFF, 4'b0001};
        vecs[2]  = '{OP_OR,  16'h000F, 16'h0019, 16'h001F, 4'b0000};
        vecs[3]  = '{OP_AND, 16'h0000, 16'h0000, 16'h0000, 4'b1000};
        vecs[4]  = '{OP_NOT, 16'h0003, 16'h0000, 16'hFFFC, 4'b1000};
        vecs[5]  = '{OP_XOR, 16'h8000, 16'h0001, 16'h8001, 4'b0100};
        vecs[6]  = '{OP_NEG, 16'h0001, 16'h0000, 16'hFFFF, 4'b0100};
        vecs[7]  = '{OP_CMP, 16'h0005, 16'h0007, 16'hFFFE, 4'b0110};
        vecs[8]  = '{OP_MOV, 16'h1234, 16'h0000, 16'h1234, 4'b0110};
        vecs[9]  = '{4'hF,   16'h1234, 16'h5678, 16'h0000, 4'b0110};
        vecs[10] = '{OP_ADD, 16'h7FFF, 16'h0001, 16'h8000, 4'b0101};

        // Reset with both requests pending: nothing may be granted.
        rst_i = 1'b0; req_i = '0; op_i = '0; data1_i = '0; data2_i = '0;
        drive(0, OP_ADD, 16'h1, 16'h1);
        drive(1, OP_ADD, 16'h2, 16'h2);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rst_ack", 32'(ack_o), 32'h0);
            check("rst_busy", 32'(busy_o), 32'h0);
            check("rst_alu_en", 32'(alu_en_o), 32'h0);
            check("rst_rsp", {12'h0, rsp_flags_o, rsp_data_o}, 32'h0);
        end
        req_i = '0; rst_i = 1'b1;
        tick();
        check("idle_busy", 32'(busy_o), 32'h0);

        // Contention from rr_ptr=0: req0, req1, req0 at 4-cycle spacing.
        drive(0, OP_SUB, 16'h8000, 16'h0001);
        drive(1, OP_OR, 16'd15, 16'd25);
        push(0, 16'h7FFF, 4'b0001);
        push(1, 16'd31, 4'b0000);
        push(0, 16'h7FFF, 4'b0001);
        wait_ack(0, c0);
        check("cont_lat0", 32'(c0), 32'd3);
        wait_ack(1, c1);
        check("cont_gap1", 32'(c1), 32'd4);
        wait_ack(0, c2);
        check("cont_gap2", 32'(c2), 32'd4);
        req_i = '0;
        tick();

        // Single ADD: alu_en only in t+1, ack in t+3.
        drive(0, OP_ADD, 16'hFFFF, 16'h0001);
        push(0, 16'h0000, 4'b1010);
        check("lat_t_en", 32'(alu_en_o), 32'h0);
        tick();
        check("lat_t1_en", 32'(alu_en_o), 32'h1);
        check("lat_t1_op", 32'(alu_op), 32'(OP_ADD));
        tick();
        check("lat_t2_en", 32'(alu_en_o), 32'h0);
        check("lat_t2_ack", 32'(ack_o), 32'h0);
        tick();
        check("lat_t3_ack", 32'(ack_o), 32'h1);
        req_i = '0;
        tick();

        for (int i = 0; i < 11; i++)
            do_txn(0, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_data, vecs[i].exp_flags);
        tick();

        // Reset during FLAG aborts without ack; rr_ptr returns to 0.
        drive(0, OP_ADD, 16'h0001, 16'h0001);
        tick();
        check("abort_exec", 32'(alu_en_o), 32'h1);
        tick();
        check("abort_flag_busy", 32'(busy_o), 32'h1);
        rst_i = 1'b0; req_i = '0;
        tick();
        check("abort_ack", 32'(ack_o), 32'h0);
        check("abort_busy", 32'(busy_o), 32'h0);
        rst_i = 1'b1;
        tick();
        drive(0, OP_OR, 16'h00AA, 16'h0000);
        drive(1, OP_OR, 16'h8000, 16'h0000);
        push(0, 16'h00AA, 4'b0000);
        wait_ack(0, c0);
        check("post_rst_winner", 32'(ack_o), 32'h1);
        req_i = '0;
        tick();

        // Operand change after grant must not reach the ALU.
        drive(0, OP_ADD, 16'h0010, 16'h0001);
        push(0, 16'h0011, 4'b0000);
        tick();
        data1_i[15:0] = 16'h0100;
        check("hold_d1", 32'(alu_d1), 32'h0010);
        wait_ack(0, c0);
        req_i = '0;

        for (int i = 0; i < 6; i++) tick();
        check("sb_drained", 32'(sb.size()), 32'h0);
        check("final_busy", 32'(busy_o), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single ALU datapath between NREQ independent requesters, such as the decode/execute path and a debug/microcode port.
- Round-robin arbitration.
- Latches the winner's opcode and operands, then sequences the ALU through one enabled cycle.
- Waits for the ALU's registered flags and returns result plus flags with a one-cycle ack pulse.
- Sits between the requesters and the ALU instance; the ALU's alu_en is owned exclusively by this block.

Parameters:
- NREQ, 2, number of requesters; legal range 2..8.
- IDXW, $clog2(NREQ), width of the winner index. Derived; not to be overridden.

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  synchronous, active-low reset (0 = reset, sampled on clk_i rising edge)
- req_i  in  NREQ  per-requester request, level
- op_i  in  4*NREQ  opcode per requester; requester k uses bits [4k+3:4k]
- data1_i  in  16*NREQ  operand 1 per requester, packed the same way
- data2_i  in  16*NREQ  operand 2 per requester
- ack_o  out  NREQ  one-hot, one-cycle completion pulse
- rsp_data_o  out  16  result; valid while ack_o != 0
- rsp_flags_o  out  4  {zf,sf,cf,of}; valid while ack_o != 0
- busy_o  out  1  high in any state other than IDLE
- alu_op_o  out  4  to ALU op_i
- alu_data1_o  out  16  to ALU data1_i
- alu_data2_o  out  16  to ALU data2_i
- alu_en_o  out  1  to ALU alu_en
- alu_data_i  in  16  from ALU data_o
- alu_zf_i, alu_sf_i, alu_cf_i, alu_of_i  in  1 each  from ALU flag outputs

Behaviour:
- Reset (rst_i==0 at a rising edge):
  - state=IDLE, rr_ptr=0.
  - ack_o=0, rsp_data_o=0, rsp_flags_o=0, busy_o=0, alu_en_o=0.
  - Latched op/operands/winner cleared to 0.
  - Reset mid-operation aborts the transaction: no ack is issued for it.
- IDLE:
  - If req_i==0, stay.
  - Otherwise pick the winner: the first asserted req scanning from rr_ptr upward, wrapping modulo NREQ.
  - Latch the winner's op/data1/data2 and its index.
  - Set rr_ptr=(winner+1) mod NREQ. Go to EXEC.
- EXEC (1 cycle):
  - alu_en_o=1; alu_op_o/alu_data1_o/alu_data2_o driven from the latched registers.
  - At the edge: rsp_data_o<=alu_data_i (the ALU result is combinational). Go to FLAG.
- FLAG (1 cycle):
  - alu_en_o=0; the ALU holds its flags, which were updated by the EXEC edge.
  - At the edge: rsp_flags_o<={alu_zf_i,alu_sf_i,alu_cf_i,alu_of_i}, and ack_o<=onehot(winner). Go to RESP.
- RESP (1 cycle):
  - ack_o one-hot high, rsp_* valid. At the edge: ack_o<=0, go to IDLE.
  - rsp_data_o/rsp_flags_o hold their values until the next transaction overwrites them.
- Latency:
  - req sampled in IDLE at cycle t, ack_o high in cycle t+3.
  - Minimum spacing between grants is 4 cycles.
- alu_en_o is high only in EXEC. Outside EXEC, alu_op_o/data outputs hold the latched values; the ALU ignores them.
- Requester protocol:
  - Hold req_i and operands stable until ack.
  - req_i is sampled only in IDLE, so operand changes after the grant have no effect.
  - After ack, the requester must drop req_i by the next IDLE cycle or it is treated as a new request.
- A requester dropping req_i after the grant does not cancel the op; ack is still issued.
- Flags for NOT/NEG/MOV/MOVHI/MOVLO are the ALU's unchanged previous flags; they are returned as-is, by design.
- CMP returns its subtraction result in rsp_data_o; requesters discard it.
- Simultaneous requests: strict round-robin from rr_ptr; no requester is starved (worst-case wait is NREQ-1 transactions).
- Unknown opcodes are passed through; the ALU returns data 0.

Decomposition:
- tangle_config.v gains:
  - state encodings ARB_IDLE=2'd0, ARB_EXEC=2'd1, ARB_FLAG=2'd2, ARB_RESP=2'd3;
  - flag-vector bit positions FLG_ZF=3, FLG_SF=2, FLG_CF=1, FLG_OF=0.
- Opcode defines are reused unchanged.
- One sub-module, rr_pick: combinational round-robin selector.
  - Inputs: req vector and rr_ptr.
  - Outputs: valid and winner index.
  - The FSM, latches and response registers stay in alu_arbiter.

Test Plan:
- Reset: drive rst_i=0 for 2 cycles with req_i=2'b11 -> ack_o=0, busy_o=0, alu_en_o=0, rsp_*=0; no grant until rst_i=1.
- Single ADD: req0 with ADD 16'hFFFF+16'h0001 at t -> alu_en_o high only at t+1; ack_o=2'b01 at t+3; rsp_data_o=16'h0000, rsp_flags_o=4'b1010 (zf=1, cf=1).
- Contention: req_i=2'b11 held, req0 SUB 16'h8000-16'h0001, req1 OR 16'd15|16'd25.
  - req0 acked first: data 16'h7FFF, flags 4'b0001.
  - req1 acked 4 cycles later: data 16'd31, flags 4'b0000.
  - Then req0 again (alternation).
- Stale flags: AND 16'h0|16'h0 (flags 4'b1000), then NOT 16'h0003 -> rsp_data_o=16'hFFFC, rsp_flags_o=4'b1000.
- Reset mid-op: assert rst_i=0 during FLAG -> no ack_o pulse; next request completes normally with rr_ptr=0.
- Operand change after grant: change data1_i of req0 during EXEC -> rsp_data_o reflects the operand latched in IDLE.
